// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory request per load or store, stalls until ack, formats loads and registers writeback.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] MEM_PCplus4,
    input  logic [19:0] MEM_BranchAddr,
    input  logic [31:0] MEM_immediate,
    input  logic        MEM_cntl_MemWrite,
    input  logic        MEM_cntl_MemRead,
    input  logic        MEM_cntl_RegWrite,
    input  logic [2:0]  MEM_sel_MemToReg,
    input  logic [2:0]  MEM_funct,
    input  logic [31:0] MEM_ALUResult,
    input  logic [4:0]  MEM_WriteRegNum,
    input  logic [31:0] MEM_WriteMemData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misalign_fault,
    output logic [31:0] WB_WriteData,
    output logic [4:0]  WB_WriteRegNum,
    output logic        WB_cntl_RegWrite
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_lo;
    logic [2:0]  r_funct;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_reg;
    logic        r_wb_rw;

    logic        w_is_mem;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misalign;
    logic        w_memop;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;

    // Stores only know byte/half/word; loads also use funct[2] as the unsigned flag.
    assign w_is_mem  = MEM_cntl_MemRead | MEM_cntl_MemWrite;
    assign w_is_byte = MEM_cntl_MemWrite ? (MEM_funct == 3'b000) : (MEM_funct[1:0] == 2'b00);
    assign w_is_half = MEM_cntl_MemWrite ? (MEM_funct == 3'b001) : (MEM_funct[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem &&
                        ((w_is_half && MEM_ALUResult[0]) ||
                         (!w_is_byte && !w_is_half && (MEM_ALUResult[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_memop = w_is_mem & ~w_misalign;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_stall = 1'b0;
        if (!reset) begin
            if (r_state == S_IDLE) w_stall = w_memop;
            else                   w_stall = !dmem_ack;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_WriteMemData;
        if (MEM_cntl_MemWrite) begin
            if (w_is_byte) begin
                w_be    = 4'b0001 << MEM_ALUResult[1:0];
                w_wdata = {4{MEM_WriteMemData[7:0]}};
            end else if (w_is_half) begin
                w_be    = 4'b0011 << {MEM_ALUResult[1], 1'b0};
                w_wdata = {2{MEM_WriteMemData[15:0]}};
            end
        end
    end

    always_comb begin
        case (r_lo)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (MEM_sel_MemToReg)
            3'b001:  w_wb_data = w_load_data;
            3'b010:  w_wb_data = MEM_immediate;
            3'b011:  w_wb_data = {12'b0, MEM_BranchAddr};
            3'b100:  w_wb_data = {12'b0, MEM_PCplus4};
            default: w_wb_data = MEM_ALUResult;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'b0;
            r_be      <= 4'b0;
            r_wdata   <= 32'b0;
            r_lo      <= 2'b0;
            r_funct   <= 3'b0;
            r_wb_data <= 32'b0;
            r_wb_reg  <= 5'b0;
            r_wb_rw   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_memop) begin
                    r_state <= S_BUSY;
                    r_req   <= 1'b1;
                    r_we    <= MEM_cntl_MemWrite;
                    r_addr  <= {MEM_ALUResult[31:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_lo    <= MEM_ALUResult[1:0];
                    r_funct <= MEM_funct;
                end
            end else if (dmem_ack) begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
            end
            // A stalled edge inserts a bubble; the held instruction writes back once the stall drops.
            if (w_stall) begin
                r_wb_rw <= 1'b0;
            end else begin
                r_wb_data <= w_wb_data;
                r_wb_reg  <= MEM_WriteRegNum;
                r_wb_rw   <= MEM_cntl_RegWrite & ~w_misalign;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_fault;
    always_ff @(posedge clk) begin
        if (reset) r_fault <= 1'b0;
        else       r_fault <= (r_state == S_IDLE) && w_misalign;
    end
    assign misalign_fault = r_fault;
`else
    assign misalign_fault = 1'b0;
`endif

    assign dmem_req         = r_req;
    assign dmem_we          = r_we;
    assign dmem_addr        = r_addr;
    assign dmem_be          = r_be;
    assign dmem_wdata       = r_wdata;
    assign stall            = w_stall;
    assign WB_WriteData     = r_wb_data;
    assign WB_WriteRegNum   = r_wb_reg;
    assign WB_cntl_RegWrite = r_wb_rw;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: table of single instructions plus hand sequences for wait states, reset and misalignment.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] MEM_PCplus4, MEM_BranchAddr;
    logic [31:0] MEM_immediate, MEM_ALUResult, MEM_WriteMemData;
    logic        MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite;
    logic [2:0]  MEM_sel_MemToReg, MEM_funct;
    logic [4:0]  MEM_WriteRegNum;
    logic        dmem_req, dmem_we, dmem_ack, stall, misalign_fault, WB_cntl_RegWrite;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, WB_WriteData;
    logic [3:0]  dmem_be;
    logic [4:0]  WB_WriteRegNum;

    mem_stage_lsu dut (
        .clk(clk), .reset(reset),
        .MEM_PCplus4(MEM_PCplus4), .MEM_BranchAddr(MEM_BranchAddr), .MEM_immediate(MEM_immediate),
        .MEM_cntl_MemWrite(MEM_cntl_MemWrite), .MEM_cntl_MemRead(MEM_cntl_MemRead),
        .MEM_cntl_RegWrite(MEM_cntl_RegWrite), .MEM_sel_MemToReg(MEM_sel_MemToReg),
        .MEM_funct(MEM_funct), .MEM_ALUResult(MEM_ALUResult), .MEM_WriteRegNum(MEM_WriteRegNum),
        .MEM_WriteMemData(MEM_WriteMemData),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .misalign_fault(misalign_fault),
        .WB_WriteData(WB_WriteData), .WB_WriteRegNum(WB_WriteRegNum), .WB_cntl_RegWrite(WB_cntl_RegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rw;
        logic [2:0]  sel, funct;
        logic [31:0] alu, wdat, rdata, imm;
        logic [19:0] pc4, br;
        logic [4:0]  rn;
        logic [31:0] exp_wb, exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rn;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[18];
    int   total = 0;
    int   bad   = 0;
    int   stall_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic rd, logic wr, logic rw, logic [2:0] sel, logic [2:0] funct,
                                logic [31:0] alu, logic [31:0] wdat, logic [31:0] rdata, logic [31:0] imm,
                                logic [19:0] pc4, logic [19:0] br, logic [4:0] rn, logic [31:0] exp_wb,
                                logic [31:0] exp_addr, logic [3:0] exp_be, logic [31:0] exp_wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.sel = sel; v.funct = funct;
        v.alu = alu; v.wdat = wdat; v.rdata = rdata; v.imm = imm; v.pc4 = pc4; v.br = br;
        v.rn = rn; v.exp_wb = exp_wb; v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        MEM_cntl_MemRead  = v.rd;
        MEM_cntl_MemWrite = v.wr;
        MEM_cntl_RegWrite = v.rw;
        MEM_sel_MemToReg  = v.sel;
        MEM_funct         = v.funct;
        MEM_ALUResult     = v.alu;
        MEM_WriteMemData  = v.wdat;
        MEM_immediate     = v.imm;
        MEM_PCplus4       = v.pc4;
        MEM_BranchAddr    = v.br;
        MEM_WriteRegNum   = v.rn;
    endtask

    task automatic drive_nop();
        MEM_cntl_MemRead  = 1'b0;
        MEM_cntl_MemWrite = 1'b0;
        MEM_cntl_RegWrite = 1'b0;
        MEM_sel_MemToReg  = 3'b000;
        MEM_funct         = 3'b010;
        MEM_ALUResult     = 32'h0;
        MEM_WriteRegNum   = 5'd0;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [4:0] rn);
        wb_t e;
        e.data = data;
        e.rn   = rn;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction; memory accesses get an ack in their first BUSY cycle.
    task automatic apply_vec(input vec_t v);
        logic memop;
        memop = v.rd | v.wr;
        drive(v);
        if (v.rw) push_exp(v.exp_wb, v.rn);
        @(negedge clk);
        check("stall_issue", stall, memop);
        check("req_idle", dmem_req, 1'b0);
        tick();
        if (memop) begin
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            @(negedge clk);
            check("req_busy", dmem_req, 1'b1);
            check("addr", dmem_addr, v.exp_addr);
            check("we", dmem_we, v.wr);
            check("stall_ack", stall, 1'b0);
            if (v.wr) begin
                check("be", dmem_be, v.exp_be);
                check("wdata", dmem_wdata, v.exp_wdata);
            end
            tick();
            dmem_ack = 1'b0;
        end
        drive_nop();
    endtask

    // Writeback scoreboard: every RegWrite pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (reset === 1'b0 && WB_cntl_RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got reg %0d data %h expected no writeback", WB_WriteRegNum, WB_WriteData);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_data", WB_WriteData, e.data);
                check("wb_reg", {27'b0, WB_WriteRegNum}, {27'b0, e.rn});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        //            rd wr rw sel     funct   alu           wdat          rdata         imm           pc4       br        rn     exp_wb        exp_addr      be       exp_wdata
        vecs[0]  = mk(0, 0, 1, 3'b000, 3'b010, 32'h12345678, 32'h0,        32'h0,        32'h0,        20'h0,    20'h0,    5'd3,  32'h12345678, 32'h0,        4'h0,    32'h0);
        vecs[1]  = mk(0, 0, 1, 3'b010, 3'b010, 32'h11111111, 32'h0,        32'h0,        32'hCAFEF00D, 20'h0,    20'h0,    5'd4,  32'hCAFEF00D, 32'h0,        4'h0,    32'h0);
        vecs[2]  = mk(0, 0, 1, 3'b011, 3'b010, 32'h22222222, 32'h0,        32'h0,        32'h0,        20'h0,    20'hFEDCB, 5'd5, 32'h000FEDCB, 32'h0,        4'h0,    32'h0);
        vecs[3]  = mk(0, 0, 1, 3'b100, 3'b010, 32'h33333333, 32'h0,        32'h0,        32'h0,        20'h00ABC, 20'h0,   5'd6,  32'h00000ABC, 32'h0,        4'h0,    32'h0);
        vecs[4]  = mk(0, 0, 1, 3'b101, 3'b010, 32'h0F0F0F0F, 32'h0,        32'h0,        32'hFFFFFFFF, 20'h1,    20'h2,    5'd7,  32'h0F0F0F0F, 32'h0,        4'h0,    32'h0);
        vecs[5]  = mk(0, 0, 1, 3'b111, 3'b010, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,        20'h1,    20'h2,    5'd8,  32'hA5A5A5A5, 32'h0,        4'h0,    32'h0);
        vecs[6]  = mk(1, 0, 1, 3'b001, 3'b000, 32'h00000103, 32'h0,        32'h80FF1234, 32'h0,        20'h0,    20'h0,    5'd10, 32'hFFFFFF80, 32'h00000100, 4'h0,    32'h0);
        vecs[7]  = mk(1, 0, 1, 3'b001, 3'b101, 32'h00000102, 32'h0,        32'h80FF1234, 32'h0,        20'h0,    20'h0,    5'd11, 32'h000080FF, 32'h00000100, 4'h0,    32'h0);
        vecs[8]  = mk(1, 0, 1, 3'b001, 3'b001, 32'h00000102, 32'h0,        32'h80FF1234, 32'h0,        20'h0,    20'h0,    5'd12, 32'hFFFF80FF, 32'h00000100, 4'h0,    32'h0);
        vecs[9]  = mk(1, 0, 1, 3'b001, 3'b100, 32'h00000101, 32'h0,        32'h80FF1234, 32'h0,        20'h0,    20'h0,    5'd13, 32'h00000012, 32'h00000100, 4'h0,    32'h0);
        vecs[10] = mk(1, 0, 1, 3'b001, 3'b000, 32'h00000102, 32'h0,        32'h80FF1234, 32'h0,        20'h0,    20'h0,    5'd14, 32'hFFFFFFFF, 32'h00000100, 4'h0,    32'h0);
        vecs[11] = mk(1, 0, 1, 3'b001, 3'b010, 32'h00000200, 32'h0,        32'h89ABCDEF, 32'h0,        20'h0,    20'h0,    5'd15, 32'h89ABCDEF, 32'h00000200, 4'h0,    32'h0);
        vecs[12] = mk(1, 0, 1, 3'b001, 3'b001, 32'h00000204, 32'h0,        32'h1234F00D, 32'h0,        20'h0,    20'h0,    5'd16, 32'hFFFFF00D, 32'h00000204, 4'h0,    32'h0);
        vecs[13] = mk(0, 1, 0, 3'b000, 3'b000, 32'h00000101, 32'h000000A5, 32'h0,        32'h0,        20'h0,    20'h0,    5'd0,  32'h0,        32'h00000100, 4'b0010, 32'hA5A5A5A5);
        vecs[14] = mk(0, 1, 0, 3'b000, 3'b001, 32'h00000106, 32'h1234BEEF, 32'h0,        32'h0,        20'h0,    20'h0,    5'd0,  32'h0,        32'h00000104, 4'b1100, 32'hBEEFBEEF);
        vecs[15] = mk(0, 1, 0, 3'b000, 3'b010, 32'h00000108, 32'hDEADBEEF, 32'h0,        32'h0,        20'h0,    20'h0,    5'd0,  32'h0,        32'h00000108, 4'b1111, 32'hDEADBEEF);
        vecs[16] = mk(0, 1, 0, 3'b000, 3'b000, 32'h0000010F, 32'h12345677, 32'h0,        32'h0,        20'h0,    20'h0,    5'd0,  32'h0,        32'h0000010C, 4'b1000, 32'h77777777);
        vecs[17] = mk(1, 0, 1, 3'b000, 3'b010, 32'h00000040, 32'h0,        32'h12345678, 32'h0,        20'h0,    20'h0,    5'd17, 32'h00000040, 32'h00000040, 4'h0,    32'h0);

        // Reset with a load presented: stall must stay low and all registers clear.
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        reset      = 1'b1;
        drive(vecs[11]);
        tick();
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        tick();
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", dmem_be, 4'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_fault", misalign_fault, 1'b0);
        check("rst_wbdata", WB_WriteData, 32'h0);
        check("rst_wbreg", WB_WriteRegNum, 5'd0);
        check("rst_wbrw", WB_cntl_RegWrite, 1'b0);
        drive_nop();
        MEM_WriteMemData = 32'h0;
        MEM_immediate    = 32'h0;
        MEM_PCplus4      = 20'h0;
        MEM_BranchAddr   = 20'h0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) apply_vec(vecs[i]);

        // SW with three wait cycles before ack.
        drive(mk(0, 1, 0, 3'b000, 3'b010, 32'h00000104, 32'hDEADBEEF, 32'h0, 32'h0, 20'h0, 20'h0,
                 5'd0, 32'h0, 32'h0, 4'h0, 32'h0));
        stall_cnt = 0;
        @(negedge clk);
        if (stall) stall_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            if (stall) stall_cnt++;
            check("sw_wait_req", dmem_req, 1'b1);
            check("sw_wait_addr", dmem_addr, 32'h00000104);
            check("sw_wait_be", dmem_be, 4'b1111);
            check("sw_wait_wdata", dmem_wdata, 32'hDEADBEEF);
            check("sw_wait_stall", stall, 1'b1);
        end
        tick();
        dmem_ack = 1'b1;
        @(negedge clk);
        if (stall) stall_cnt++;
        check("sw_ack_req", dmem_req, 1'b1);
        tick();
        dmem_ack = 1'b0;
        drive_nop();
        check("sw_done_req", dmem_req, 1'b0);
        check("sw_stall_cycles", stall_cnt, 4);
        check("sw_no_wb", WB_cntl_RegWrite, 1'b0);

        // Stray ack while idle.
        dmem_ack = 1'b1;
        @(negedge clk);
        check("stray_stall", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        check("stray_req", dmem_req, 1'b0);

        // Reset during BUSY abandons the load.
        drive(mk(1, 0, 1, 3'b001, 3'b010, 32'h00000300, 32'h0, 32'h0, 32'h0, 20'h0, 20'h0,
                 5'd9, 32'h0, 32'h0, 4'h0, 32'h0));
        tick();
        check("rb_req_busy", dmem_req, 1'b1);
        reset = 1'b1;
        drive_nop();
        @(negedge clk);
        check("rb_stall_rst", stall, 1'b0);
        tick();
        check("rb_req_rst", dmem_req, 1'b0);
        check("rb_wbrw_rst", WB_cntl_RegWrite, 1'b0);
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        check("rb_stray_stall", stall, 1'b0);
        check("rb_stray_req", dmem_req, 1'b0);
        tick();
        dmem_ack = 1'b0;
        check("rb_after_req", dmem_req, 1'b0);
        check("rb_after_wbrw", WB_cntl_RegWrite, 1'b0);
        apply_vec(vecs[9]);

        // LW at 0x102.
        drive(mk(1, 0, 1, 3'b001, 3'b010, 32'h00000102, 32'h0, 32'h0, 32'h0, 20'h0, 20'h0,
                 5'd18, 32'h0, 32'h0, 4'h0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        check("mis_stall", stall, 1'b0);
        tick();
        drive_nop();
        check("mis_fault", misalign_fault, 1'b1);
        check("mis_req", dmem_req, 1'b0);
        check("mis_wbrw", WB_cntl_RegWrite, 1'b0);
        tick();
        check("mis_fault_pulse", misalign_fault, 1'b0);
        check("mis_req_after", dmem_req, 1'b0);
`else
        push_exp(32'hCAFEBABE, 5'd18);
        @(negedge clk);
        check("mis_stall", stall, 1'b1);
        tick();
        check("mis_req", dmem_req, 1'b1);
        check("mis_addr", dmem_addr, 32'h00000100);
        check("mis_fault", misalign_fault, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEBABE;
        tick();
        dmem_ack = 1'b0;
        drive_nop();
        check("mis_req_after", dmem_req, 1'b0);
`endif

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
